// File: rtl/y86_fetch_unit_if.sv
// y86_fetch_unit_if
//   Groups the fetch unit's three handshakes into one bundle:
//   - instruction-memory byte read (imem_req_o/imem_addr_o out,
//     imem_ack_i/imem_data_i/imem_err_i back)
//   - instruction record toward decode (inst_valid_o + record fields out,
//     inst_ready_i back)
//   - next-PC return from PC select (pc_next_valid_i/pc_next_i in)
//   Modports:
//     master : the fetch unit
//     slave  : the environment (memory, decode, PC select)
interface y86_fetch_unit_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic [7:0]  imem_data_i;
  logic        imem_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [3:0]  icode_o;
  logic [3:0]  ifun_o;
  logic [3:0]  ra_o;
  logic [3:0]  rb_o;
  logic [63:0] valc_o;
  logic [63:0] valp_o;
  logic [63:0] pc_o;
  logic [2:0]  stat_o;
  logic        pc_next_valid_i;
  logic [63:0] pc_next_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_data_i, imem_err_i,
    output inst_valid_o,
    input  inst_ready_i,
    output icode_o, ifun_o, ra_o, rb_o, valc_o, valp_o, pc_o, stat_o,
    input  pc_next_valid_i, pc_next_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_data_i, imem_err_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  icode_o, ifun_o, ra_o, rb_o, valc_o, valp_o, pc_o, stat_o,
    output pc_next_valid_i, pc_next_i
  );
endinterface

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit
//   Fetch stage of the y86 CPU. Reads an instruction one byte at a time from
//   instruction memory starting at the PC, decodes icode/ifun/rA/rB/valC,
//   computes valP and a status, presents the record to decode and then waits
//   for PC select to return the next PC. Any non-AOK record parks the unit in
//   HALTED until reset.
//   Ports:
//     clk_i    : clock, all state changes on the rising edge
//     rst_n_i  : synchronous reset, active high despite the name
//     bus      : y86_fetch_unit_if.master (memory, decode and next-PC handshakes)
//   Parameters:
//     RESET_PC : PC loaded by reset
//     MAX_WAIT : consecutive no-ack request cycles tolerated before ADR
module y86_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  y86_fetch_unit_if.master bus
);

  localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH_OP, ST_FETCH_REG, ST_FETCH_CONST,
    ST_PRESENT, ST_WAIT_PC, ST_HALTED
  } state_t;

  // Instruction length in bytes for a legal icode.
  function automatic logic [3:0] inst_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    return len;
  endfunction

  // Function code out of range for its icode.
  function automatic logic ifun_bad(input logic [3:0] icode, input logic [3:0] ifun);
    logic bad;
    case (icode)
      4'h2, 4'h7: bad = (ifun > 4'h6);
      4'h6:       bad = (ifun > 4'h3);
      default:    bad = (ifun != 4'h0);
    endcase
    return bad;
  endfunction

  state_t            state_r, state_s;
  logic [63:0]       pc_r, pc_s, addr_r, addr_s, valc_r, valc_s, valp_r, valp_s;
  logic              req_r, req_s, valid_r, valid_s;
  logic [3:0]        icode_r, icode_s, ifun_r, ifun_s, ra_r, ra_s, rb_r, rb_s;
  logic [2:0]        stat_r, stat_s, kbyte_r, kbyte_s, fin_stat_s;
  logic [WAIT_W-1:0] wait_r, wait_s;
  logic              byte_done_s, finish_s, start_s;
  logic [63:0]       start_pc_s;

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    addr_s     = addr_r;
    req_s      = req_r;
    valid_s    = valid_r;
    icode_s    = icode_r;
    ifun_s     = ifun_r;
    ra_s       = ra_r;
    rb_s       = rb_r;
    valc_s     = valc_r;
    valp_s     = valp_r;
    stat_s     = stat_r;
    kbyte_s    = kbyte_r;
    wait_s     = wait_r;
    finish_s   = 1'b0;
    fin_stat_s = STAT_AOK;
    start_s    = 1'b0;
    start_pc_s = pc_r;
    // acks are only meaningful while a request is outstanding
    byte_done_s = req_r & bus.imem_ack_i;

    case (state_r)
      ST_IDLE: begin
        start_s = 1'b1;
      end
      ST_FETCH_OP, ST_FETCH_REG, ST_FETCH_CONST: begin
        if (byte_done_s) begin
          addr_s = addr_r + 64'd1;
          wait_s = '0;
          if (bus.imem_err_i) begin
            finish_s   = 1'b1;
            fin_stat_s = STAT_ADR;
          end else if (state_r == ST_FETCH_OP) begin
            icode_s = bus.imem_data_i[7:4];
            ifun_s  = bus.imem_data_i[3:0];
            if ((icode_s > 4'hB) || ifun_bad(icode_s, ifun_s)) begin
              finish_s   = 1'b1;
              fin_stat_s = STAT_INS;
            end else begin
              case (icode_s)
                4'h0, 4'h1, 4'h9: finish_s = 1'b1;
                4'h7, 4'h8: begin
                  state_s = ST_FETCH_CONST;
                  kbyte_s = 3'd0;
                end
                default: state_s = ST_FETCH_REG;
              endcase
            end
          end else if (state_r == ST_FETCH_REG) begin
            ra_s = bus.imem_data_i[7:4];
            rb_s = bus.imem_data_i[3:0];
            // irmovq/rmmovq/mrmovq carry a constant after the register byte
            if ((icode_r >= 4'h3) && (icode_r <= 4'h5)) begin
              state_s = ST_FETCH_CONST;
              kbyte_s = 3'd0;
            end else begin
              finish_s = 1'b1;
            end
          end else begin
            valc_s[{kbyte_r, 3'b000} +: 8] = bus.imem_data_i;
            kbyte_s = kbyte_r + 3'd1;
            if (kbyte_r == 3'd7) begin
              finish_s = 1'b1;
            end else begin
              state_s = ST_FETCH_CONST;
            end
          end
        end else if (wait_r == WAIT_LAST) begin
          finish_s   = 1'b1;
          fin_stat_s = STAT_ADR;
        end else begin
          wait_s = wait_r + WAIT_W'(1'b1);
        end
      end
      ST_PRESENT: begin
        if (bus.inst_ready_i) begin
          valid_s = 1'b0;
          state_s = (stat_r == STAT_AOK) ? ST_WAIT_PC : ST_HALTED;
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_WAIT_PC: begin
        if (bus.pc_next_valid_i) begin
          start_s    = 1'b1;
          start_pc_s = bus.pc_next_i;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_HALTED: begin
        state_s = ST_HALTED;
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
        valid_s = 1'b0;
      end
    endcase

    // A new fetch clears the previous record so untouched fields read 0/F.
    if (start_s) begin
      state_s = ST_FETCH_OP;
      pc_s    = start_pc_s;
      addr_s  = start_pc_s;
      req_s   = 1'b1;
      valid_s = 1'b0;
      icode_s = 4'h0;
      ifun_s  = 4'h0;
      ra_s    = 4'hF;
      rb_s    = 4'hF;
      valc_s  = 64'd0;
      valp_s  = 64'd0;
      stat_s  = STAT_AOK;
      kbyte_s = 3'd0;
      wait_s  = '0;
    end else if (finish_s) begin
      state_s = ST_PRESENT;
      req_s   = 1'b0;
      valid_s = 1'b1;
      valp_s  = pc_r + {60'd0, inst_len(icode_s)};
      if ((fin_stat_s == STAT_AOK) && (icode_s == 4'h0)) begin
        stat_s = STAT_HLT;
      end else begin
        stat_s = fin_stat_s;
      end
    end else begin
      stat_s = stat_s;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      icode_r <= 4'h0;
      ifun_r  <= 4'h0;
      ra_r    <= 4'hF;
      rb_r    <= 4'hF;
      valc_r  <= 64'd0;
      valp_r  <= 64'd0;
      stat_r  <= STAT_AOK;
      kbyte_r <= 3'd0;
      wait_r  <= '0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      addr_r  <= addr_s;
      req_r   <= req_s;
      valid_r <= valid_s;
      icode_r <= icode_s;
      ifun_r  <= ifun_s;
      ra_r    <= ra_s;
      rb_r    <= rb_s;
      valc_r  <= valc_s;
      valp_r  <= valp_s;
      stat_r  <= stat_s;
      kbyte_r <= kbyte_s;
      wait_r  <= wait_s;
    end
  end

  assign bus.imem_req_o   = req_r;
  assign bus.imem_addr_o  = addr_r;
  assign bus.inst_valid_o = valid_r;
  assign bus.icode_o      = icode_r;
  assign bus.ifun_o       = ifun_r;
  assign bus.ra_o         = ra_r;
  assign bus.rb_o         = rb_r;
  assign bus.valc_o       = valc_r;
  assign bus.valp_o       = valp_r;
  assign bus.pc_o         = pc_r;
  assign bus.stat_o       = stat_r;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb_y86_fetch_unit
//   Directed bench for y86_fetch_unit. A byte-addressed memory model answers
//   requests (zero-wait, every-3rd-cycle, or never), a reference model reads
//   that memory the way the y86 instruction format says to and produces the
//   expected record, and one compare process checks every presented record.
module tb_y86_fetch_unit;
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;

  y86_fetch_unit_if bus ();

  y86_fetch_unit #(.RESET_PC(64'd0), .MAX_WAIT(16)) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem     [longint unsigned];
  bit         err_set [longint unsigned];
  int         ack_period = 1;
  bit         ack_off    = 1'b0;

  bit          chk_en = 1'b0;
  logic [63:0] exp_pc, exp_valc, exp_valp;
  logic [3:0]  exp_icode, exp_ifun, exp_ra, exp_rb;
  logic [2:0]  exp_stat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic bit is_err(input logic [63:0] a);
    return err_set.exists(a) != 0;
  endfunction

  task automatic put_bytes(input logic [63:0] a, input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[a + 64'(i)] = bytes[79 - 8*i -: 8];
  endtask

  // Reference: walk the instruction at pc byte by byte per the y86 format.
  task automatic model_fetch(input logic [63:0] pc);
    logic [7:0]  b;
    logic [63:0] a;
    int          len;
    bit          has_reg, has_const, ok;
    exp_pc = pc; exp_icode = 4'h0; exp_ifun = 4'h0; exp_ra = 4'hF; exp_rb = 4'hF;
    exp_valc = 64'd0; exp_valp = 64'd0; exp_stat = 3'd1; chk_en = 1'b1;
    if (is_err(pc)) begin exp_stat = 3'd3; return; end
    b = rd(pc);
    exp_icode = b[7:4]; exp_ifun = b[3:0];
    has_reg = 1'b0; has_const = 1'b0; len = 1;
    case (exp_icode)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; has_reg = 1'b1; end
      4'h7, 4'h8:             begin len = 9; has_const = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 10; has_reg = 1'b1; has_const = 1'b1; end
      default:                begin exp_stat = 3'd4; return; end
    endcase
    if (exp_icode == 4'h2 || exp_icode == 4'h7) ok = (exp_ifun <= 4'h6);
    else if (exp_icode == 4'h6) ok = (exp_ifun <= 4'h3);
    else ok = (exp_ifun == 4'h0);
    if (!ok) begin exp_stat = 3'd4; return; end
    a = pc + 64'd1;
    if (has_reg) begin
      if (is_err(a)) begin exp_stat = 3'd3; return; end
      b = rd(a); exp_ra = b[7:4]; exp_rb = b[3:0]; a = a + 64'd1;
    end
    if (has_const) begin
      for (int i = 0; i < 8; i++) begin
        if (is_err(a)) begin exp_stat = 3'd3; return; end
        exp_valc = exp_valc | ({56'd0, rd(a)} << (8*i));
        a = a + 64'd1;
      end
    end
    exp_valp = pc + 64'(len);
    if (exp_icode == 4'h0) exp_stat = 3'd2;
  endtask

  task automatic model_timeout(input logic [63:0] pc);
    exp_pc = pc; exp_icode = 4'h0; exp_ifun = 4'h0; exp_ra = 4'hF; exp_rb = 4'hF;
    exp_valc = 64'd0; exp_valp = 64'd0; exp_stat = 3'd3; chk_en = 1'b1;
  endtask

  // Memory responder: answers outstanding requests at the falling edge.
  initial begin
    int cnt;
    cnt = 0;
    bus.imem_ack_i = 1'b0; bus.imem_data_i = 8'h00; bus.imem_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bus.imem_req_o === 1'b1 && !ack_off) begin
        cnt++;
        if (cnt % ack_period == 0) begin
          bus.imem_ack_i  = 1'b1;
          bus.imem_data_i = rd(bus.imem_addr_o);
          bus.imem_err_i  = is_err(bus.imem_addr_o);
        end else begin
          bus.imem_ack_i = 1'b0; bus.imem_data_i = 8'h00; bus.imem_err_i = 1'b0;
        end
      end else begin
        cnt = 0;
        bus.imem_ack_i = 1'b0; bus.imem_data_i = 8'h00; bus.imem_err_i = 1'b0;
      end
    end
  end

  // Compare every presented record against the reference.
  always @(negedge clk_i) begin
    if (chk_en && rst_n_i == 1'b0 && bus.inst_valid_o === 1'b1) begin
      chk("rec_pc",    bus.pc_o,    exp_pc);
      chk("rec_icode", 64'(bus.icode_o), 64'(exp_icode));
      chk("rec_ifun",  64'(bus.ifun_o),  64'(exp_ifun));
      chk("rec_ra",    64'(bus.ra_o),    64'(exp_ra));
      chk("rec_rb",    64'(bus.rb_o),    64'(exp_rb));
      chk("rec_valc",  bus.valc_o,  exp_valc);
      chk("rec_stat",  64'(bus.stat_o),  64'(exp_stat));
      chk("rec_req_low", 64'(bus.imem_req_o), 64'd0);
      if (exp_stat == 3'd1 || exp_stat == 3'd2) chk("rec_valp", bus.valp_o, exp_valp);
    end
  end

  task automatic do_reset();
    rst_n_i = 1'b1; chk_en = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_req",   64'(bus.imem_req_o),   64'd0);
    chk("rst_valid", 64'(bus.inst_valid_o), 64'd0);
    chk("rst_pc",    bus.pc_o,              64'd0);
    chk("rst_icode", 64'(bus.icode_o),      64'd0);
    chk("rst_ra",    64'(bus.ra_o),         64'hF);
    chk("rst_rb",    64'(bus.rb_o),         64'hF);
    chk("rst_valc",  bus.valc_o,            64'd0);
    chk("rst_valp",  bus.valp_o,            64'd0);
    chk("rst_stat",  64'(bus.stat_o),       64'd1);
    rst_n_i = 1'b0;
  endtask

  task automatic wait_valid(input int exp_req);
    int req_cyc, n;
    req_cyc = 0; n = 0;
    while (bus.inst_valid_o !== 1'b1 && n < 300) begin
      if (bus.imem_req_o === 1'b1) req_cyc++;
      @(negedge clk_i);
      n++;
    end
    chk("valid_seen", 64'(bus.inst_valid_o), 64'd1);
    chk("req_cycles", 64'(req_cyc), 64'(exp_req));
  endtask

  task automatic handshake();
    bus.inst_ready_i = 1'b1;
    @(negedge clk_i);
    bus.inst_ready_i = 1'b0;
    chk("hs_valid_drop", 64'(bus.inst_valid_o), 64'd0);
    chk("hs_req_low",    64'(bus.imem_req_o),   64'd0);
  endtask

  task automatic give_pc(input logic [63:0] pc);
    bus.pc_next_valid_i = 1'b1; bus.pc_next_i = pc;
    @(negedge clk_i);
    bus.pc_next_valid_i = 1'b0;
    chk("next_req",  64'(bus.imem_req_o), 64'd1);
    chk("next_addr", bus.imem_addr_o,     pc);
    chk("next_pc",   bus.pc_o,            pc);
  endtask

  task automatic check_halted(input int n);
    bus.pc_next_valid_i = 1'b1; bus.pc_next_i = 64'h40;
    repeat (n) begin
      @(negedge clk_i);
      chk("halted_req",   64'(bus.imem_req_o),   64'd0);
      chk("halted_valid", 64'(bus.inst_valid_o), 64'd0);
    end
    bus.pc_next_valid_i = 1'b0;
  endtask

  initial begin
    bus.inst_ready_i = 1'b0; bus.pc_next_valid_i = 1'b0; bus.pc_next_i = 64'd0;
    put_bytes(64'h000, 80'h30F3_0A00_0000_0000_0000, 10); // irmovq $10,%rbx
    put_bytes(64'h100, 80'h7000_0200_0000_0000_0000, 9);  // jmp 0x200
    put_bytes(64'h600, 80'h30F3_0A00_0000_0000_0000, 10);
    put_bytes(64'h300, 80'h5012_AA00_0000_0000_0000, 10); // mrmovq, bad 3rd byte
    err_set[64'h302] = 1'b1;
    put_bytes(64'h020, 80'hC000_0000_0000_0000_0000, 1);  // illegal icode

    // irmovq, then jmp with wait states, then reset in the middle of valC
    do_reset(); model_fetch(64'h0); wait_valid(10);
    chk("irmovq_icode", 64'(bus.icode_o), 64'h3);
    chk("irmovq_rb",    64'(bus.rb_o),    64'h3);
    chk("irmovq_valc",  bus.valc_o,       64'd10);
    chk("irmovq_valp",  bus.valp_o,       64'h0A);
    handshake();
    model_fetch(64'h100); ack_period = 3; give_pc(64'h100); wait_valid(27);
    chk("model_jmp_valc", exp_valc,   64'h200);
    chk("jmp_valc",       bus.valc_o, 64'h200);
    chk("jmp_valp",       bus.valp_o, 64'h109);
    handshake(); ack_period = 1;
    give_pc(64'h600);
    repeat (4) @(negedge clk_i);
    chk("midfetch_req", 64'(bus.imem_req_o), 64'd1);
    rst_n_i = 1'b1; chk_en = 1'b0;
    @(negedge clk_i);
    chk("midrst_req", 64'(bus.imem_req_o), 64'd0);
    chk("midrst_pc",  bus.pc_o,            64'd0);
    rst_n_i = 1'b0;
    model_fetch(64'h0); wait_valid(10);
    chk("refetch_valc", bus.valc_o, 64'd10);
    handshake();
    model_fetch(64'h300); give_pc(64'h300); wait_valid(3);
    chk("mrmovq_stat", 64'(bus.stat_o), 64'd3);
    chk("mrmovq_ra",   64'(bus.ra_o),   64'h1);
    handshake(); check_halted(6);

    // nop under backpressure, then illegal opcode
    put_bytes(64'h000, 80'h1000_0000_0000_0000_0000, 1);
    do_reset(); model_fetch(64'h0); wait_valid(1);
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_icode", 64'(bus.icode_o),    64'h1);
      chk("bp_valp",  bus.valp_o,          64'h1);
      chk("bp_ra",    64'(bus.ra_o),       64'hF);
      chk("bp_valid", 64'(bus.inst_valid_o), 64'd1);
    end
    handshake();
    model_fetch(64'h20); give_pc(64'h20); wait_valid(1);
    chk("ins_stat", 64'(bus.stat_o), 64'd4);
    handshake(); check_halted(6);

    // halt instruction
    put_bytes(64'h000, 80'h0000_0000_0000_0000_0000, 1);
    do_reset(); model_fetch(64'h0); wait_valid(1);
    chk("halt_stat", 64'(bus.stat_o), 64'd2);
    chk("halt_valp", bus.valp_o,      64'd1);
    handshake(); check_halted(3);

    // ifun boundaries: cmovg (2/6) legal, 2/7 illegal
    put_bytes(64'h000, 80'h2645_0000_0000_0000_0000, 2);
    put_bytes(64'h010, 80'h2700_0000_0000_0000_0000, 1);
    do_reset(); model_fetch(64'h0); wait_valid(2);
    chk("cmov_valp", bus.valp_o, 64'd2);
    handshake();
    model_fetch(64'h10); give_pc(64'h10); wait_valid(1);
    chk("ifun7_stat", 64'(bus.stat_o), 64'd4);
    handshake(); check_halted(3);

    // memory never answers
    ack_off = 1'b1;
    do_reset(); model_timeout(64'h0); wait_valid(16);
    chk("timeout_stat", 64'(bus.stat_o), 64'd3);
    handshake(); check_halted(3);
    ack_off = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/y86_fetch_unit.md
Name: y86_fetch_unit

Overview:
Fetch stage directly upstream of the decode stage in the y86 CPU. It holds the PC and reads instruction bytes one at a time over a byte-wide instruction-memory handshake. It assembles icode/ifun/rA/rB/valC, computes valP and an instruction status, then hands the instruction to decode over a valid/ready handshake. After each handoff it waits for the PC-select logic to return the next PC.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
MAX_WAIT, 16, cycles with no imem_ack_i before the fetch aborts with ADR status

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_n_i  in  1  synchronous, active-high reset (asserted = 1, sampled on clk_i rising edge)
imem_req_o  out  1  byte read request
imem_addr_o  out  64  byte address of the current request
imem_ack_i  in  1  byte returned this cycle
imem_data_i  in  8  returned byte, valid when imem_ack_i=1
imem_err_i  in  1  address error, valid when imem_ack_i=1
inst_valid_o  out  1  instruction record valid toward decode
inst_ready_i  in  1  decode accepts the record
icode_o  out  4  instruction code
ifun_o  out  4  function code
ra_o  out  4  rA field (4'hF if the instruction has no register byte)
rb_o  out  4  rB field (4'hF if the instruction has no register byte)
valc_o  out  64  constant, little-endian (0 if the instruction has no constant)
valp_o  out  64  PC + instruction length, modulo 2^64
pc_o  out  64  PC of the instruction being fetched or presented
stat_o  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
pc_next_valid_i  in  1  next PC available
pc_next_i  in  64  next PC value

Behaviour:
- Reset (rst_n_i=1 at an edge):
  - State goes to IDLE; pc_o=RESET_PC; imem_req_o=0; inst_valid_o=0.
  - icode_o, ifun_o, valc_o and valp_o reset to 0; ra_o and rb_o reset to 4'hF; stat_o=AOK.
  - This overrides any state, including mid-fetch. An ack arriving in the reset cycle is ignored.
- IDLE: on the next cycle go to FETCH_OP with imem_req_o=1 and imem_addr_o=pc_o.
- Byte transfers:
  - A byte completes on any cycle where imem_req_o=1 and imem_ack_i=1 (zero-wait memory allowed).
  - On completion, imem_addr_o increments by 1 at that edge. imem_req_o stays high while more bytes are needed.
  - An N-byte instruction takes at least N cycles.
- Instruction length by icode:
  - 0, 1, 9 → 1 byte
  - 2, 6, A, B → 2 bytes
  - 7, 8 → 9 bytes
  - 3, 4, 5 → 10 bytes
- FETCH_OP:
  - Byte 0 gives icode (bits [7:4]) and ifun (bits [3:0]).
  - icode > 4'hB, or a bad ifun, sets stat=INS and goes to PRESENT. Bad ifun means: icode 2 or 7 with ifun > 6; icode 6 with ifun > 3; any other icode with ifun ≠ 0.
  - Otherwise go to FETCH_REG, FETCH_CONST or PRESENT according to the instruction format.
- FETCH_REG: byte gives rA = bits [7:4], rB = bits [3:0]. Any value, including F, is accepted.
- FETCH_CONST:
  - 3-bit byte counter k = 0..7; byte k loads valC[8k+7:8k].
  - Leave the state after k=7.
- Errors during a fetch:
  - imem_err_i on any ack sets stat=ADR and goes to PRESENT immediately; remaining fields are 0/F.
  - A wait counter resets on every ack. If it reaches MAX_WAIT, set stat=ADR and go to PRESENT.
- PRESENT:
  - imem_req_o=0; inst_valid_o=1; all record outputs held stable until inst_valid_o & inst_ready_i.
  - valP = pc_o + length, computed with 64-bit wrap.
  - stat=HLT when icode=0.
- After handshake:
  - If stat is AOK, go to WAIT_PC.
  - If stat is anything else, go to HALTED.
- WAIT_PC: inst_valid_o=0. On pc_next_valid_i=1, load pc_o=pc_next_i and go to FETCH_OP next cycle (req=1).
- HALTED: no requests, inst_valid_o=0; pc_next_valid_i is ignored. Only reset exits this state.
- pc_next_valid_i is ignored in every state except WAIT_PC.
- imem_ack_i is ignored while imem_req_o=0.

Test Plan:
- irmovq $10,%rbx: reset, memory at 0 = 30 F3 0A 00 00 00 00 00 00 00, zero-wait ack → 10 req cycles, then inst_valid_o with icode=3, ifun=0, ra=F, rb=3, valc=10, valp=0x0A, stat=AOK.
- Backpressure: hold inst_ready_i=0 for 5 cycles on a nop at PC=0 → outputs stable (icode=1, valp=1, ra=rb=F), imem_req_o=0. Raise ready → next cycle WAIT_PC. pc_next_i=0x20 → next request addr=0x20.
- Jump with wait states: jmp at 0x100 with bytes 70 + 8-byte dest 0x200, ack every 3rd cycle → valc=0x200, valp=0x109. The request stays high through the wait states.
- Bad opcode: byte 0 = C0 → stat=INS, valid for one handshake, then HALTED. No further requests even with pc_next_valid_i=1.
- Memory error: imem_err_i on the 3rd byte of mrmovq → stat=ADR, valid, then HALTED. Separately, no ack for 16 cycles → stat=ADR.
- Reset mid-fetch: assert rst_n_i during the valC bytes → next cycle req=0 and pc_o=RESET_PC. Release reset → refetch from RESET_PC and return the correct record.
